// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: single-cycle logic/arith/compare/lui, iterative shifter.
// Optional macro OVERFLOW_TRAP_EN enables signed overflow reporting on add/sub.
module alu_exec_unit #(
    parameter int SHIFT_STEP = 1,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        alu_ctrl,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_res;
    logic              r_ovf;
    logic [5:0]        r_amt;
    logic [1:0]        r_kind;

    logic              w_accept;
    logic              w_is_shift;
    logic [4:0]        w_amt;
    logic [1:0]        w_kind;
    logic [5:0]        w_step;
    logic [DATA_W-1:0] w_sum, w_diff, w_alu_res, w_shifted;
    logic              w_alu_ovf;

    assign w_accept   = in_valid & in_ready;
    assign w_is_shift = (alu_ctrl <= 5'd5);
    assign w_amt      = (alu_ctrl < 5'd3) ? shamt : src_a[4:0];
    assign w_kind     = (alu_ctrl >= 5'd3) ? 2'(alu_ctrl - 5'd3) : alu_ctrl[1:0];
    assign w_sum      = src_a + src_b;
    assign w_diff     = src_a - src_b;
    assign w_step     = (r_amt > STEP) ? STEP : r_amt;

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (alu_ctrl)
            5'd6, 5'd7: w_alu_res = w_sum;
            5'd8, 5'd9: w_alu_res = w_diff;
            5'd10:      w_alu_res = src_a & src_b;
            5'd11:      w_alu_res = src_a | src_b;
            5'd12:      w_alu_res = src_a ^ src_b;
            5'd13:      w_alu_res = ~(src_a | src_b);
            5'd14:      w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            5'd15:      w_alu_res = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
            5'd16:      w_alu_res = {src_b[15:0], 16'h0000};
            default:    w_alu_res = '0;
        endcase
`ifdef OVERFLOW_TRAP_EN
        // Trap only the signed variants; the unsigned forms wrap silently.
        if (alu_ctrl == 5'd6)
            w_alu_ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) && (w_sum[DATA_W-1] != src_a[DATA_W-1]);
        else if (alu_ctrl == 5'd8)
            w_alu_ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) && (w_diff[DATA_W-1] != src_a[DATA_W-1]);
`endif
    end

    always_comb begin
        case (r_kind)
            2'd0:    w_shifted = r_res << w_step;
            2'd1:    w_shifted = r_res >> w_step;
            default: w_shifted = $unsigned($signed(r_res) >>> w_step);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (w_is_shift && w_amt != 5'd0) ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_amt <= STEP) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // Shift ops park the operand in r_res and shift it in place; others land the result directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res  <= '0;
            r_ovf  <= 1'b0;
            r_amt  <= '0;
            r_kind <= '0;
        end else if (w_accept) begin
            if (w_is_shift) begin
                r_res  <= src_b;
                r_ovf  <= 1'b0;
                r_amt  <= {1'b0, w_amt};
                r_kind <= w_kind;
            end else begin
                r_res  <= w_alu_res;
                r_ovf  <= w_alu_ovf;
                r_amt  <= '0;
            end
        end else if (r_state == S_SHIFT) begin
            r_res <= w_shifted;
            r_amt <= r_amt - w_step;
        end
    end

    assign result = r_res;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases, random ops vs. behavioural model, reset abort.
module tb_alu_exec_unit;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_ctrl = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_unit #(.SHIFT_STEP(STEP), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .shamt(shamt), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [4:0] c, input logic [4:0] sh,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o, output int lat);
        int amt;
        longint sa, sb, s;
        r   = '0;
        o   = 1'b0;
        lat = 1;
        amt = (c < 5'd3) ? int'(sh) : int'(a[4:0]);
        sa  = $signed(a);
        sb  = $signed(b);
        s   = 0;
        case (c)
            5'd0, 5'd3: r = b << amt;
            5'd1, 5'd4: r = b >> amt;
            5'd2, 5'd5: r = 32'($signed(b) >>> amt);
            5'd6, 5'd7: r = a + b;
            5'd8, 5'd9: r = a - b;
            5'd10: r = a & b;
            5'd11: r = a | b;
            5'd12: r = a ^ b;
            5'd13: r = ~(a | b);
            5'd14: r = (sa < sb) ? 32'd1 : 32'd0;
            5'd15: r = (a < b) ? 32'd1 : 32'd0;
            5'd16: r = {b[15:0], 16'h0000};
            default: r = '0;
        endcase
        if (c <= 5'd5 && amt > 0) lat = 1 + (amt + STEP - 1) / STEP;
`ifdef OVERFLOW_TRAP_EN
        if (c == 5'd6) s = sa + sb;
        if (c == 5'd8) s = sa - sb;
        if (c == 5'd6 || c == 5'd8) o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`endif
    endfunction

    task automatic do_op(input logic [4:0] c, input logic [4:0] sh, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input string name);
        logic [31:0] exp_r, held;
        logic        exp_o;
        int          exp_lat, lat;
        bit          busy_ok;
        model(c, sh, a, b, exp_r, exp_o, exp_lat);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_before: in_ready=%b required 1", name, in_ready);
        end
        alu_ctrl = c; shamt = sh; src_a = a; src_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom; alu_ctrl = 5'($urandom); shamt = 5'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (!busy_ok) begin
            n_err++;
            $display("FAIL %s busy_in_ready: in_ready high while busy, required 0", name);
        end
        n_cmp++;
        if (result !== exp_r) begin
            n_err++;
            $display("FAIL %s result: got %h required %h", name, result, exp_r);
        end
        n_cmp++;
        if (ovf !== exp_o) begin
            n_err++;
            $display("FAIL %s ovf: got %b required %b", name, ovf, exp_o);
        end
        held = exp_r;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            src_a = $urandom; src_b = $urandom; alu_ctrl = 5'($urandom % 17);
            @(posedge clk); #1;
            n_cmp++;
            if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || ovf !== exp_o) begin
                n_err++;
                $display("FAIL %s hold%0d: result=%h ov=%b rdy=%b required %h 1 0", name, k,
                         result, out_valid, in_ready, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 32'h0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: ov=%b result=%h ovf=%b required 0 0 0", out_valid, result, ovf);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        do_op(5'd6, 5'd0, 32'h0000_0005, 32'h0000_0003, 0, "add_basic");
        do_op(5'd2, 5'd4, 32'h0, 32'h8000_00F0, 0, "sra_4");
        do_op(5'd4, 5'd0, 32'h0000_0020, 32'hDEAD_BEEF, 0, "srlv_amt0");
        do_op(5'd14, 5'd0, 32'hFFFF_FFFF, 32'h0, 3, "slt_neg");
        do_op(5'd15, 5'd0, 32'hFFFF_FFFF, 32'h0, 3, "sltu_big");
        do_op(5'd6, 5'd0, 32'h7FFF_FFFF, 32'h1, 0, "add_ovf");
        do_op(5'd7, 5'd0, 32'h7FFF_FFFF, 32'h1, 0, "addu_noovf");
        do_op(5'd8, 5'd0, 32'h8000_0000, 32'h1, 1, "sub_ovf");
        do_op(5'd0, 5'd31, 32'h0, 32'h1, 0, "sll_31");
        do_op(5'd5, 5'd0, 32'h0000_001F, 32'h8000_0000, 0, "srav_31");
        do_op(5'd16, 5'd0, 32'h0, 32'hABCD_1234, 0, "lui");
        do_op(5'd13, 5'd0, 32'h0F0F_0000, 32'h0000_00F0, 0, "nor");
        do_op(5'd23, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "code23");
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            do_op(5'($urandom), 5'($urandom), $urandom, $urandom, $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            do_op(5'($urandom_range(6, 16)), 5'd0, $urandom, $urandom, 0, "b2b");
        end
    endtask

    task automatic test_abort();
        alu_ctrl = 5'd0; shamt = 5'd31; src_a = 32'h0; src_b = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 32'h0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: out_valid=%b result=%h required 0 00000000", out_valid, result);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        do_op(5'd16, 5'd0, 32'h0, 32'h0000_1234, 0, "lui_after_abort");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
